// File: rtl/pattern_out_if.sv
// rtl/pattern_out_if.sv - din valid/ready handshake into the pattern playback engine
interface pattern_out_if;
  logic [15:0] din;
  logic        din_valid;
  logic        din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/pattern_out.sv
// rtl/pattern_out.sv - FIFO-buffered 16-bit pattern playback, one word per divider period
module pattern_out #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                core_clk,
  input  logic                core_rst,
  pattern_out_if.slave        din_if,
  input  logic                out_en_i,
  input  logic [23:0]         out_divider_i,
  input  logic [31:0]         out_length_i,
  input  logic [15:0]         idle_level_i,
  output logic [15:0]         pattern_data_o,
  output logic                pattern_strobe_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                underrun_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   HALF_CNT = (DEPTH_LOG2+1)'(DEPTH / 2);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic                  out_en_1t_q;
  logic [15:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [31:0]           accepted_q, accepted_d, emitted_q, emitted_d;
  logic [23:0]           div_cnt_q, div_cnt_d;
  logic [15:0]           data_q, data_d;
  logic                  strobe_q, strobe_d;
  logic                  underrun_q, underrun_d;
  logic                  start, full, empty, len_limited, ready, push, pop, flush;

  assign start       = out_en_i & ~out_en_1t_q;
  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign len_limited = (out_length_i != 32'd0);
  // Ready depends only on registered state and static config, never on din_valid.
  assign ready       = (state_q != IDLE) & ~full & (~len_limited | (accepted_q < out_length_i));
  assign push        = din_if.din_valid & ready;
  assign flush       = (state_q == IDLE) | ~out_en_i;

  assign din_if.din_ready = ready;

  always_comb begin
    state_d    = state_q;
    accepted_d = accepted_q;
    emitted_d  = emitted_q;
    div_cnt_d  = div_cnt_q;
    data_d     = data_q;
    strobe_d   = 1'b0;
    underrun_d = underrun_q;
    pop        = 1'b0;
    if (push) begin
      accepted_d = accepted_q + 32'd1;
    end
    case (state_q)
      IDLE: begin
        data_d = idle_level_i;
        if (start) begin
          state_d    = PRIME;
          accepted_d = '0;
          emitted_d  = '0;
        end
      end
      PRIME: begin
        underrun_d = 1'b0;
        div_cnt_d  = '0;
        if ((count_q >= HALF_CNT) || (len_limited && (32'(count_q) >= out_length_i))) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (div_cnt_q != '0) begin
          div_cnt_d = div_cnt_q - 24'd1;
        end else if (len_limited && (emitted_q == out_length_i)) begin
          state_d = DONE;
        end else if (!empty) begin
          pop       = 1'b1;
          data_d    = mem_q[rd_ptr_q];
          strobe_d  = 1'b1;
          emitted_d = emitted_q + 32'd1;
          div_cnt_d = (out_divider_i == '0) ? '0 : out_divider_i - 24'd1;
        end else begin
          // Empty tick: div_cnt stays 0 so the next cycle retries.
          underrun_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
    if (!out_en_i) begin
      state_d    = IDLE;
      pop        = 1'b0;
      strobe_d   = 1'b0;
      data_d     = idle_level_i;
      accepted_d = accepted_q;
      emitted_d  = emitted_q;
      underrun_d = underrun_q;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din_if.din;
    end
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state_q     <= IDLE;
      out_en_1t_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      accepted_q  <= '0;
      emitted_q   <= '0;
      div_cnt_q   <= '0;
      data_q      <= 16'h0000;
      strobe_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_en_1t_q <= out_en_i;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      accepted_q  <= accepted_d;
      emitted_q   <= emitted_d;
      div_cnt_q   <= div_cnt_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      underrun_q  <= underrun_d;
    end
  end

  assign pattern_data_o   = data_q;
  assign pattern_strobe_o = strobe_q;
  assign busy_o           = (state_q == PRIME) | (state_q == RUN);
  assign done_o           = (state_q == DONE);
  assign underrun_o       = underrun_q;

endmodule

// File: tb/tb_pattern_out.sv
// tb/tb_pattern_out.sv - randomized self-checking bench for pattern_out
module tb_pattern_out;

  logic        core_clk = 1'b0;
  logic        core_rst = 1'b0;
  logic        out_en_i = 1'b0;
  logic [23:0] out_divider_i = '0;
  logic [31:0] out_length_i = '0;
  logic [15:0] idle_level_i = 16'h1234;
  logic [15:0] pattern_data_o;
  logic        pattern_strobe_o, busy_o, done_o, underrun_o;

  pattern_out_if dif();

  pattern_out #(.DEPTH_LOG2(4)) dut (
    .core_clk         (core_clk),
    .core_rst         (core_rst),
    .din_if           (dif),
    .out_en_i         (out_en_i),
    .out_divider_i    (out_divider_i),
    .out_length_i     (out_length_i),
    .idle_level_i     (idle_level_i),
    .pattern_data_o   (pattern_data_o),
    .pattern_strobe_o (pattern_strobe_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .underrun_o       (underrun_o)
  );

  always #5 core_clk = ~core_clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          start_edge = 0;
  int          done_edge = -1;
  bit          src_rand = 1'b0;
  int          push_edge[$];
  logic [15:0] push_data[$];
  int          strobe_edge[$];
  logic [15:0] strobe_data[$];
  int          exp_s[$];
  bit          exp_under;
  int          exp_done;

  // One clock: sample handshake at negedge, record events #1 after the posedge.
  task automatic cycle();
    logic        pushed;
    logic [15:0] w;
    @(negedge core_clk);
    pushed = dif.din_valid && dif.din_ready;
    w = dif.din;
    @(posedge core_clk);
    cyc++;
    #1;
    if (pushed) begin
      push_edge.push_back(cyc);
      push_data.push_back(w);
      dif.din = src_rand ? 16'($urandom) : w + 16'd1;
    end
    if (pattern_strobe_o) begin
      strobe_edge.push_back(cyc);
      strobe_data.push_back(pattern_data_o);
    end
    if (done_o && done_edge < 0) done_edge = cyc;
  endtask

  task automatic start_run(int len, int div, logic [15:0] first);
    push_edge.delete();
    push_data.delete();
    strobe_edge.delete();
    strobe_data.delete();
    done_edge = -1;
    out_length_i = len;
    out_divider_i = div;
    dif.din = first;
    out_en_i = 1'b1;
    start_edge = cyc + 1;
  endtask

  // Word-level timing model: word k leaves one period after word k-1, but never
  // earlier than the edge after it was pushed; the first leaves one edge after
  // priming ends, which needs min(8,len) words buffered and at least one prime cycle.
  function automatic void build_model(int len, int per);
    int thr, n, r, s;
    exp_s.delete();
    exp_under = 1'b0;
    exp_done = -1;
    thr = (len != 0 && len < 8) ? len : 8;
    n = push_edge.size();
    if (len != 0 && n > len) n = len;
    if (n < thr) return;
    r = (push_edge[thr-1] + 1 > start_edge + 1) ? push_edge[thr-1] + 1 : start_edge + 1;
    s = r + 1;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        s = exp_s[k-1] + per;
        if (push_edge[k] + 1 > s) begin
          exp_under = 1'b1;
          s = push_edge[k] + 1;
        end
      end
      exp_s.push_back(s);
    end
    if (len != 0 && n == len) exp_done = exp_s[n-1] + per;
  endfunction

  task automatic test_reset();
    #1 core_rst = 1'b1;
    #1;
    n_checks++;
    if ({busy_o, done_o, underrun_o, pattern_strobe_o, dif.din_ready} !== 5'b0 || pattern_data_o !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b data %h want 00000 data 0000",
               {busy_o, done_o, underrun_o, pattern_strobe_o, dif.din_ready}, pattern_data_o);
    end
    @(posedge core_clk);
    #1 core_rst = 1'b0;
    cycle();
    n_checks++;
    if (pattern_data_o !== 16'h1234 || dif.din_ready !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got data %h ready %b busy %b want 1234 0 0", pattern_data_o, dif.din_ready, busy_o);
    end
    idle_level_i = 16'h5A3C;
    start_run(0, 3, 16'($urandom));
    dif.din_valid = 1'b1;
    for (int i = 0; i < 100 && strobe_edge.size() < 3; i++) cycle();
    n_checks++;
    if (strobe_edge.size() < 3) begin
      n_fail++;
      $display("FAIL reset_prerun got %0d strobes want 3", strobe_edge.size());
    end
    core_rst = 1'b1;
    #1;
    n_checks++;
    if ({busy_o, done_o, underrun_o, pattern_strobe_o, dif.din_ready} !== 5'b0 || pattern_data_o !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_midrun got %b data %h want 00000 data 0000",
               {busy_o, done_o, underrun_o, pattern_strobe_o, dif.din_ready}, pattern_data_o);
    end
    out_en_i = 1'b0;
    dif.din_valid = 1'b0;
    #1 core_rst = 1'b0;
    cycle();
    n_checks++;
    if (pattern_data_o !== 16'h5A3C || busy_o !== 1'b0 || dif.din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after got data %h busy %b ready %b want 5a3c 0 0", pattern_data_o, busy_o, dif.din_ready);
    end
    start_run(8, 1, 16'h0100);
    dif.din_valid = 1'b1;
    for (int i = 0; i < 100 && done_edge < 0; i++) cycle();
    dif.din_valid = 1'b0;
    n_checks++;
    if (strobe_data.size() != 8 || strobe_data[0] !== 16'h0100) begin
      n_fail++;
      $display("FAIL reset_fifo_empty got %0d strobes first %h want 8 0100",
               strobe_data.size(), strobe_data.size() > 0 ? strobe_data[0] : 16'hxxxx);
    end
    out_en_i = 1'b0;
    cycle();
  endtask

  task automatic test_length8();
    int ready_viol;
    ready_viol = 0;
    idle_level_i = 16'h0000;
    src_rand = 1'b0;
    start_run(8, 3, 16'h0001);
    dif.din_valid = 1'b1;
    for (int i = 0; i < 150 && done_edge < 0; i++) begin
      cycle();
      if (push_edge.size() >= 8 && dif.din_ready) ready_viol++;
    end
    repeat (3) cycle();
    dif.din_valid = 1'b0;
    build_model(8, 3);
    n_checks++;
    if (strobe_edge.size() != 8 || push_edge.size() != 8) begin
      n_fail++;
      $display("FAIL len8_count got %0d strobes %0d pushes want 8 8", strobe_edge.size(), push_edge.size());
    end
    for (int k = 0; k < 8 && k < strobe_edge.size(); k++) begin
      n_checks++;
      if (strobe_data[k] !== 16'(k + 1) || strobe_edge[k] != exp_s[k]) begin
        n_fail++;
        $display("FAIL len8_word[%0d] got %h@%0d want %h@%0d", k, strobe_data[k], strobe_edge[k], k + 1, exp_s[k]);
      end
    end
    n_checks++;
    if (strobe_edge.size() == 8 && strobe_edge[7] - strobe_edge[0] != 21) begin
      n_fail++;
      $display("FAIL len8_spacing got %0d want 21", strobe_edge[7] - strobe_edge[0]);
    end
    n_checks++;
    if (done_edge != exp_done || done_edge != start_edge + 34) begin
      n_fail++;
      $display("FAIL len8_done_edge got %0d want %0d", done_edge, start_edge + 34);
    end
    n_checks++;
    if (ready_viol != 0) begin
      n_fail++;
      $display("FAIL len8_ready_after_8 got %0d cycles ready want 0", ready_viol);
    end
    n_checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || pattern_data_o !== 16'h0008 || underrun_o !== 1'b0) begin
      n_fail++;
      $display("FAIL len8_done_state got done %b busy %b data %h under %b want 1 0 0008 0",
               done_o, busy_o, pattern_data_o, underrun_o);
    end
    out_en_i = 1'b0;
    cycle();
    n_checks++;
    if (done_o !== 1'b0 || pattern_data_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL len8_exit got done %b data %h want 0 0000", done_o, pattern_data_o);
    end
  endtask

  task automatic test_stream_div0();
    int busy_bad, under_bad;
    logic [15:0] first;
    busy_bad = 0;
    under_bad = 0;
    first = 16'($urandom);
    src_rand = 1'b0;
    start_run(0, 0, first);
    dif.din_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (!busy_o) busy_bad++;
      if (underrun_o) under_bad++;
    end
    dif.din_valid = 1'b0;
    out_en_i = 1'b0;
    cycle();
    build_model(0, 1);
    n_checks++;
    if (strobe_edge.size() != 50) begin
      n_fail++;
      $display("FAIL div0_count got %0d want 50", strobe_edge.size());
    end
    for (int k = 0; k < strobe_edge.size() && k < exp_s.size(); k++) begin
      n_checks++;
      if (strobe_data[k] !== 16'(first + 16'(k)) || strobe_edge[k] != exp_s[k] || strobe_edge[k] != start_edge + 10 + k) begin
        n_fail++;
        $display("FAIL div0_word[%0d] got %h@%0d want %h@%0d", k, strobe_data[k], strobe_edge[k], 16'(first + 16'(k)), start_edge + 10 + k);
      end
    end
    n_checks++;
    if (busy_bad != 0 || under_bad != 0) begin
      n_fail++;
      $display("FAIL div0_status got %0d not-busy %0d underrun cycles want 0 0", busy_bad, under_bad);
    end
  endtask

  task automatic test_underrun();
    int s10;
    src_rand = 1'b0;
    start_run(0, 2, 16'($urandom));
    dif.din_valid = 1'b1;
    for (int i = 0; i < 50 && push_edge.size() < 10; i++) cycle();
    dif.din_valid = 1'b0;
    for (int i = 0; i < 100 && strobe_edge.size() < 10; i++) cycle();
    s10 = (strobe_edge.size() >= 10) ? strobe_edge[9] : cyc;
    while (cyc < s10 + 5) begin
      cycle();
      if (cyc == s10 + 1) begin
        n_checks++;
        if (underrun_o !== 1'b0) begin
          n_fail++;
          $display("FAIL under_early got %b want 0", underrun_o);
        end
      end
      if (cyc == s10 + 2) begin
        n_checks++;
        if (underrun_o !== 1'b1) begin
          n_fail++;
          $display("FAIL under_set got %b want 1", underrun_o);
        end
      end
    end
    dif.din_valid = 1'b1;
    for (int i = 0; i < 50 && push_edge.size() < 16; i++) cycle();
    dif.din_valid = 1'b0;
    repeat (40) cycle();
    build_model(0, 2);
    n_checks++;
    if (strobe_edge.size() != 16 || exp_under !== 1'b1) begin
      n_fail++;
      $display("FAIL under_count got %0d strobes model_under %b want 16 1", strobe_edge.size(), exp_under);
    end
    for (int k = 0; k < strobe_edge.size() && k < exp_s.size(); k++) begin
      n_checks++;
      if (strobe_data[k] !== push_data[k] || strobe_edge[k] != exp_s[k]) begin
        n_fail++;
        $display("FAIL under_word[%0d] got %h@%0d want %h@%0d", k, strobe_data[k], strobe_edge[k], push_data[k], exp_s[k]);
      end
    end
    n_checks++;
    if (strobe_edge.size() >= 11 && strobe_edge[10] - strobe_edge[9] != 7) begin
      n_fail++;
      $display("FAIL under_stretch got %0d want 7", strobe_edge[10] - strobe_edge[9]);
    end
    out_en_i = 1'b0;
    cycle();
    n_checks++;
    if (underrun_o !== 1'b1 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL under_sticky got under %b busy %b want 1 0", underrun_o, busy_o);
    end
    start_run(0, 2, 16'h0000);
    cycle();
    cycle();
    n_checks++;
    if (underrun_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL under_clear got under %b busy %b want 0 1", underrun_o, busy_o);
    end
    out_en_i = 1'b0;
    cycle();
  endtask

  task automatic test_abort();
    idle_level_i = 16'hA5A5;
    src_rand = 1'b1;
    start_run(16, 2, 16'($urandom));
    dif.din_valid = 1'b1;
    for (int i = 0; i < 100 && strobe_edge.size() < 4; i++) cycle();
    build_model(16, 2);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (k >= strobe_edge.size() || strobe_data[k] !== push_data[k] || strobe_edge[k] != exp_s[k]) begin
        n_fail++;
        $display("FAIL abort_pre_word[%0d] got %0d strobes want word %h@%0d", k, strobe_edge.size(), push_data[k], exp_s[k]);
      end
    end
    out_en_i = 1'b0;
    cycle();
    n_checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || pattern_data_o !== 16'hA5A5 || dif.din_ready !== 1'b0 || pattern_strobe_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle got busy %b done %b data %h ready %b strobe %b want 0 0 a5a5 0 0",
               busy_o, done_o, pattern_data_o, dif.din_ready, pattern_strobe_o);
    end
    start_run(16, 2, 16'($urandom));
    for (int i = 0; i < 200 && done_edge < 0; i++) cycle();
    dif.din_valid = 1'b0;
    build_model(16, 2);
    n_checks++;
    if (strobe_edge.size() != 16 || done_edge != exp_done || done_edge < 0) begin
      n_fail++;
      $display("FAIL abort_restart got %0d strobes done@%0d want 16 done@%0d", strobe_edge.size(), done_edge, exp_done);
    end
    for (int k = 0; k < strobe_edge.size() && k < exp_s.size(); k++) begin
      n_checks++;
      if (strobe_data[k] !== push_data[k] || strobe_edge[k] != exp_s[k]) begin
        n_fail++;
        $display("FAIL abort_word[%0d] got %h@%0d want %h@%0d", k, strobe_data[k], strobe_edge[k], push_data[k], exp_s[k]);
      end
    end
    out_en_i = 1'b0;
    cycle();
  endtask

  task automatic test_full();
    int  fill, prev_fill, events, ready_bad;
    bit  pend;
    fill = 0;
    prev_fill = 0;
    events = 0;
    ready_bad = 0;
    pend = 1'b0;
    src_rand = 1'b1;
    start_run(0, 4, 16'($urandom));
    dif.din_valid = 1'b1;
    for (int i = 0; i < 90; i++) begin
      cycle();
      fill = push_edge.size() - strobe_edge.size();
      if (dif.din_ready !== (fill < 16)) ready_bad++;
      if (pend) begin
        n_checks++;
        if (push_edge.size() == 0 || push_edge[$] != cyc) begin
          n_fail++;
          $display("FAIL full_late_accept got no push at %0d want push", cyc);
        end
        pend = 1'b0;
      end
      if (prev_fill == 16 && strobe_edge.size() > 0 && strobe_edge[$] == cyc) begin
        events++;
        n_checks++;
        if (push_edge[$] == cyc) begin
          n_fail++;
          $display("FAIL full_push_blocked got push at pop edge %0d want none", cyc);
        end
        pend = 1'b1;
      end
      prev_fill = fill;
    end
    dif.din_valid = 1'b0;
    repeat (100) cycle();
    out_en_i = 1'b0;
    cycle();
    build_model(0, 4);
    n_checks++;
    if (ready_bad != 0 || events == 0) begin
      n_fail++;
      $display("FAIL full_ready got %0d bad-ready cycles %0d full pops want 0 >0", ready_bad, events);
    end
    n_checks++;
    if (strobe_edge.size() != push_edge.size()) begin
      n_fail++;
      $display("FAIL full_count got %0d strobes want %0d", strobe_edge.size(), push_edge.size());
    end
    for (int k = 0; k < strobe_edge.size() && k < exp_s.size(); k++) begin
      n_checks++;
      if (strobe_data[k] !== push_data[k] || strobe_edge[k] != exp_s[k]) begin
        n_fail++;
        $display("FAIL full_word[%0d] got %h@%0d want %h@%0d", k, strobe_data[k], strobe_edge[k], push_data[k], exp_s[k]);
      end
    end
  endtask

  initial begin
    dif.din = 16'h0000;
    dif.din_valid = 1'b0;
    test_reset();
    test_length8();
    test_stream_div0();
    test_underrun();
    test_abort();
    test_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
